sipo_deserializer: RTL

//  Serial-to-parallel stage directly downstream of the SISO shift register: samples its

---
 rtl/sipo_deserializer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-to-parallel word assembler with sync-marker alignment,
// a one-entry valid/ready output buffer and sticky overrun / framing-error flags.
//
// state | meaning
// IDLE  | unaligned; serial bits are dropped until a bit arrives with sync set
// SHIFT | aligned; every valid bit is captured, words follow back-to-back
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sin,
    input  logic             i_sin_valid,
    input  logic             i_sync,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_overrun,
    output logic             o_frame_err,
    input  logic             i_clr_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_overrun;
    logic             r_frame_err;

    logic             w_take;
    logic             w_restart;
    logic [CW-1:0]    w_cur_cnt;
    logic [CW-1:0]    w_pos;
    logic [WIDTH-1:0] w_next_shift;
    logic             w_complete;
    logic             w_frame_set;
    logic             w_accept;
    logic             w_load;
    logic             w_overrun_set;

    // Decode the current serial bit: where it lands and whether it finishes a word.
    // A sync bit or a zero count starts a fresh word, so stale bits are cleared.
    always_comb begin
        w_take       = i_sin_valid & ((r_state == SHIFT) | i_sync);
        w_restart    = i_sync | (r_cnt == '0);
        w_cur_cnt    = w_restart ? '0 : r_cnt;
        w_pos        = LSB_FIRST ? w_cur_cnt : (CW'(WIDTH - 1) - w_cur_cnt);
        w_next_shift = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (CW'(i) == w_pos) begin
                w_next_shift[i] = i_sin;
            end else begin
                w_next_shift[i] = w_restart ? 1'b0 : r_shift[i];
            end
        end
        // A sync on the last bit position is a restart, never a completion.
        w_complete    = w_take & (r_state == SHIFT) & ~i_sync & (r_cnt == CW'(WIDTH - 1));
        w_frame_set   = i_sin_valid & i_sync & (r_state == SHIFT) & (r_cnt != '0);
        w_accept      = r_out_valid & i_out_ready;
        w_load        = w_complete & (~r_out_valid | i_out_ready);
        w_overrun_set = w_complete & r_out_valid & ~i_out_ready;
    end

    // Alignment FSM with bit counter and word assembly register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_take) begin
            r_state <= SHIFT;
            r_shift <= w_next_shift;
            r_cnt   <= w_complete ? '0 : (w_cur_cnt + 1'b1);
        end
    end

    // One-entry output buffer: load on completion when empty or draining, else hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_next_shift;
            r_out_valid <= 1'b1;
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky status flags; a same-edge set takes priority over clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (i_clr_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_overrun   = r_overrun;
    assign o_frame_err = r_frame_err;

endmodule
